// File: rtl/pipe5_dmem_req_ctrl.sv
// Data-memory request controller for the 5-stage pipe: alignment check, lane steering, bus handshake, load extension.
// Optional macro PIPE5_DMEM_TIMEOUT_EN adds a bus-timeout counter that raises bus_fault.
module pipe5_dmem_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] memory_addr,
  input  logic [31:0] store_wdata,
  input  logic [2:0]  load_type,
  input  logic        flush,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_en,
  input  logic        dmem_busy,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mal_addr,
  output logic        bus_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] waddr_q;
  logic [1:0]  ofs_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  type_q;
  logic        store_q;
  logic        flushed_q;
  logic [31:0] load_q;

  logic        req, misal, accept, timeout, kill;
  logic [3:0]  be_new;
  logic [31:0] rshift, ext;

  assign req   = ex_valid & (dren | dwen);
  assign misal = (load_type[1:0] == 2'b01 && memory_addr[0]) ||
                 (load_type[1]            && memory_addr[1:0] != 2'b00);
  assign accept = (state_q == IDLE) && req && !misal && !flush && !RST;
  assign kill   = flush | flushed_q;

  always_comb begin
    be_new = 4'b1111;
    case (load_type[1:0])
      2'b00:   be_new = 4'b0001 << memory_addr[1:0];
      2'b01:   be_new = 4'b0011 << memory_addr[1:0];
      default: be_new = 4'b1111;
    endcase
  end

  assign rshift = dmem_rdata >> {ofs_q, 3'b000};
  always_comb begin
    ext = rshift;
    case (type_q)
      3'd0:    ext = {{24{rshift[7]}},  rshift[7:0]};
      3'd1:    ext = {{16{rshift[15]}}, rshift[15:0]};
      3'd4:    ext = {24'd0, rshift[7:0]};
      3'd5:    ext = {16'd0, rshift[15:0]};
      default: ext = rshift;
    endcase
  end

`ifdef PIPE5_DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (RST)                                cnt_q <= '0;
    else if (accept)                        cnt_q <= '0;
    else if (state_q == ACCESS && dmem_busy) cnt_q <= cnt_q + 1'b1;
  end
  assign timeout = (state_q == ACCESS) && dmem_busy && !RST &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      ofs_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      type_q    <= '0;
      store_q   <= 1'b0;
      flushed_q <= 1'b0;
      load_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        waddr_q   <= memory_addr[31:2];
        ofs_q     <= memory_addr[1:0];
        wdata_q   <= store_wdata << {memory_addr[1:0], 3'b000};
        be_q      <= be_new;
        type_q    <= load_type;
        store_q   <= dwen;
        flushed_q <= 1'b0;
      end else if (state_q == ACCESS && flush) begin
        flushed_q <= 1'b1;
      end
      // Result lands on the completing edge; a flushed access is drained but dropped.
      if (state_q == ACCESS && !dmem_busy && !kill && !store_q)
        load_q <= ext;
    end
  end

  always_comb begin
    state_d      = state_q;
    dmem_ren     = 1'b0;
    dmem_wen     = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_byte_en = '0;
    mem_stall    = 1'b0;
    mal_addr     = 1'b0;
    bus_fault    = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = accept;
        mal_addr  = req && misal && !flush && !RST;
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        dmem_ren     = !store_q;
        dmem_wen     = store_q;
        dmem_addr    = {waddr_q, 2'b00};
        dmem_wdata   = wdata_q;
        dmem_byte_en = be_q;
        mem_stall    = 1'b1;
        bus_fault    = timeout;
        if (timeout)         state_d = IDLE;
        else if (!dmem_busy) state_d = kill ? IDLE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_data = load_q;

endmodule

// File: tb/tb_pipe5_dmem_req_ctrl.sv
// Self-checking bench for pipe5_dmem_req_ctrl: directed corner cases plus randomized transactions vs a byte-level model.
module tb_pipe5_dmem_req_ctrl;
  logic        CLK = 1'b0;
  logic        RST, ex_valid, dren, dwen, flush, dmem_busy;
  logic [31:0] memory_addr, store_wdata, dmem_rdata;
  logic [2:0]  load_type;
  logic        dmem_ren, dmem_wen, mem_stall, mal_addr, bus_fault;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_byte_en;

  int checks = 0, errors = 0;
  logic [31:0] exp_ld = '0;
  int last_stall;

  pipe5_dmem_req_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .dren(dren), .dwen(dwen),
    .memory_addr(memory_addr), .store_wdata(store_wdata), .load_type(load_type),
    .flush(flush), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .dmem_busy(dmem_busy),
    .dmem_rdata(dmem_rdata), .load_data(load_data), .mem_stall(mem_stall),
    .mal_addr(mal_addr), .bus_fault(bus_fault));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick; @(posedge CLK); #1; endtask
  task automatic mid;  @(negedge CLK);     endtask

  function automatic int nbytes(input logic [2:0] t);
    return (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] t);
    logic [3:0] b = '0;
    int off = a % 4;
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + nbytes(t));
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w = '0;
    int off = a % 4;
    for (int i = 0; i < 4; i++) if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] rd);
    longint v = 0;
    int n = nbytes(t), off = a % 4;
    for (int j = 0; j < n; j++) v += longint'(rd[8*(off+j) +: 8]) << (8*j);
    if (!t[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  task automatic quiet;
    ex_valid = 0; dren = 0; dwen = 0; flush = 0; dmem_busy = 0;
    memory_addr = '0; store_wdata = '0; load_type = '0; dmem_rdata = '0;
  endtask

  // One request from IDLE; busy_n busy ACCESS cycles; flush_at = ACCESS cycle index carrying flush (-1 none).
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [2:0] t, input bit ld, input bit st, input int busy_n,
                     input int flush_at, input bit busy_pre);
    bit mis = (a % nbytes(t)) != 0;
    bit flushed = 0;
    last_stall = 0;
    ex_valid = 1; dren = ld; dwen = st; memory_addr = a; store_wdata = wd; load_type = t;
    flush = 0; dmem_busy = busy_pre; dmem_rdata = $urandom;
    mid;
    last_stall += int'(mem_stall);
    if (mis) begin
      chk("mal_pulse", mal_addr, 1);
      chk("mal_stall", mem_stall, 0);
      chk("mal_strobe", {dmem_ren, dmem_wen}, 0);
      tick; ex_valid = 0;
      mid;
      chk("mal_once", mal_addr, 0);
      chk("mal_next_stall", mem_stall, 0);
      chk("mal_next_strobe", {dmem_ren, dmem_wen}, 0);
      tick;
      return;
    end
    chk("acc_stall", mem_stall, 1);
    chk("acc_mal", mal_addr, 0);
    chk("acc_strobe", {dmem_ren, dmem_wen}, 0);
    tick;
    ex_valid = 0; dren = $urandom; dwen = $urandom; memory_addr = $urandom;
    store_wdata = $urandom; load_type = $urandom;
    for (int k = 0; k <= busy_n; k++) begin
      dmem_busy = (k < busy_n);
      flush = (k == flush_at);
      if (flush) flushed = 1;
      dmem_rdata = (k == busy_n) ? rd : $urandom;
      mid;
      last_stall += int'(mem_stall);
      chk("ren", dmem_ren, ld && !st);
      chk("wen", dmem_wen, st);
      chk("addr", dmem_addr, a - (a % 4));
      chk("be", dmem_byte_en, m_be(a, t));
      if (st) chk("wdata", dmem_wdata, m_wdata(a, wd));
      chk("acc_hold_stall", mem_stall, 1);
      chk("fault_idle", bus_fault, 0);
      tick;
    end
    flush = 0; dmem_busy = $urandom;
    if (!flushed && ld && !st) exp_ld = m_load(a, t, rd);
    // Decoy request: a DONE cycle must ignore it; after a flush we are already IDLE and it flags.
    ex_valid = 1; dren = 1; dwen = 0; load_type = 3'd2;
    memory_addr = flushed ? 32'h0000_0101 : 32'h0000_0100;
    mid;
    last_stall += int'(mem_stall);
    chk("post_stall", mem_stall, 0);
    chk("post_strobe", {dmem_ren, dmem_wen}, 0);
    chk("post_mal", mal_addr, flushed);
    chk("load_data", load_data, exp_ld);
    tick;
    ex_valid = 0;
  endtask

  initial begin
    quiet(); RST = 1;
    tick; tick;
    mid;
    chk("rst_ren", dmem_ren, 0);     chk("rst_wen", dmem_wen, 0);
    chk("rst_addr", dmem_addr, 0);   chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_byte_en, 0);  chk("rst_ld", load_data, 0);
    chk("rst_stall", mem_stall, 0);  chk("rst_mal", mal_addr, 0);
    chk("rst_fault", bus_fault, 0);
    tick; RST = 0;

    // LB with busy high across three cycles (acceptance + two ACCESS)
    txn(32'h0000_1003, 32'h0, 32'h80AA_BBCC, 3'd0, 1, 0, 2, -1, 1);
    chk("lb_stall_cycles", last_stall, 4);
    chk("lb_value", load_data, 32'hFFFF_FF80);
    txn(32'h0000_2002, 32'h0000_BEEF, 32'h0, 3'd1, 0, 1, 0, -1, 0);
    txn(32'h0000_3001, 32'h0, 32'h0, 3'd2, 1, 0, 0, -1, 0);
    txn(32'h0000_4000, 32'h0, 32'h1234_5678, 3'd2, 1, 0, 2, 0, 0);
    txn(32'h0000_5002, 32'h0, 32'hFEDC_8000, 3'd5, 1, 0, 0, -1, 0);
    txn(32'h0000_5004, 32'hCAFE_F00D, 32'h0, 3'd2, 1, 1, 1, -1, 0);

    // flush in IDLE suppresses acceptance
    ex_valid = 1; dren = 1; memory_addr = 32'h60; load_type = 3'd2; flush = 1;
    mid; chk("idle_flush_stall", mem_stall, 0);
    tick; quiet();
    mid; chk("idle_flush_strobe", {dmem_ren, dmem_wen}, 0);
    tick;

    for (int i = 0; i < 60; i++) begin
      logic [2:0] ts[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [2:0] t = ts[$urandom_range(0, 4)];
      int bn = $urandom_range(0, 2);
      int kind = $urandom_range(0, 2);
      int fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, bn) : -1;
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(nbytes(t) - 1);
      txn(a, $urandom, $urandom, t, kind != 1, kind != 0, bn, fa, 1'($urandom));
    end

`ifdef PIPE5_DMEM_TIMEOUT_EN
    ex_valid = 1; dren = 1; memory_addr = 32'h40; load_type = 3'd2; dmem_busy = 1;
    tick; ex_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      mid;
      chk("to_ren", dmem_ren, 1);
      chk("to_fault", bus_fault, k == 4);
      tick;
    end
    mid;
    chk("to_after_ren", dmem_ren, 0);
    chk("to_after_stall", mem_stall, 0);
    chk("to_after_fault", bus_fault, 0);
    tick; dmem_busy = 0;
`else
    ex_valid = 1; dren = 1; memory_addr = 32'h40; load_type = 3'd2; dmem_busy = 1;
    tick; ex_valid = 0;
    for (int k = 0; k < 10; k++) begin
      mid;
      chk("wait_ren", dmem_ren, 1);
      chk("wait_fault", bus_fault, 0);
      tick;
    end
    dmem_busy = 0; dmem_rdata = 32'h0BAD_F00D;
    mid; chk("wait_ren_last", dmem_ren, 1);
    tick; exp_ld = 32'h0BAD_F00D;
    mid; chk("wait_done_ld", load_data, exp_ld); chk("wait_done_stall", mem_stall, 0);
    tick;
`endif

    // reset during the second ACCESS cycle, with busy dropping late
    ex_valid = 1; dren = 1; dwen = 0; memory_addr = 32'h80; load_type = 3'd2; dmem_busy = 1;
    tick; ex_valid = 0;
    mid; chk("rsta_ren", dmem_ren, 1);
    tick; RST = 1;
    tick; dmem_busy = 0; dmem_rdata = 32'h1111_2222;
    mid;
    chk("rstm_ren", dmem_ren, 0);   chk("rstm_addr", dmem_addr, 0);
    chk("rstm_be", dmem_byte_en, 0); chk("rstm_wdata", dmem_wdata, 0);
    chk("rstm_stall", mem_stall, 0); chk("rstm_ld", load_data, 0);
    tick; RST = 0; exp_ld = '0;
    mid;
    chk("rstp_ren", dmem_ren, 0); chk("rstp_stall", mem_stall, 0);
    chk("rstp_ld", load_data, exp_ld);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule

// File: doc/pipe5_dmem_req_ctrl.md
PIPE5_DMEM_REQ_CTRL -- requirements
Module: pipe5_dmem_req_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles a data access waits before a bus fault is flagged.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port ex_valid, input, 1 bit: the execute/memory latch holds a live instruction.
REQ-005 The block SHALL have ports dren and dwen, input, 1 bit each: load request and store request from the latch.
REQ-006 The block SHALL have port memory_addr, input, 32 bits: byte address of the access.
REQ-007 The block SHALL have port store_wdata, input, 32 bits: unshifted store data.
REQ-008 The block SHALL have port load_type, input, 3 bits: funct3 encoding (LB=0, LH=1, LW=2, LBU=4, LHU=5); the same encoding gives the size for stores.
REQ-009 The block SHALL have port flush, input, 1 bit: kill the current access.
REQ-010 The block SHALL have ports dmem_ren and dmem_wen, output, 1 bit each: bus read and write strobes.
REQ-011 The block SHALL have ports dmem_addr, output, 32 bits (word-aligned), and dmem_wdata, output, 32 bits (lane-shifted).
REQ-012 The block SHALL have port dmem_byte_en, output, 4 bits: byte lane enables.
REQ-013 The block SHALL have port dmem_busy, input, 1 bit: the bus has not completed the access.
REQ-014 The block SHALL have port dmem_rdata, input, 32 bits: bus read data.
REQ-015 The block SHALL have port load_data, output, 32 bits: extracted, extended load result.
REQ-016 The block SHALL have port mem_stall, output, 1 bit: hold all upstream stages.
REQ-017 The block SHALL have ports mal_addr and bus_fault, output, 1 bit each: misaligned-access and timeout exceptions, each pulsed for one cycle.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-019 IDLE: the block SHALL enter ACCESS when ex_valid and (dren or dwen) are high, the address is aligned and flush is low; otherwise it SHALL stay in IDLE.
REQ-020 Alignment SHALL be checked as follows: a halfword requires addr[0]=0; a word requires addr[1:0]=0.
REQ-021 On a misaligned request in IDLE, the block SHALL pulse mal_addr for one cycle, issue no strobe and stay in IDLE.
REQ-022 In ACCESS, the block SHALL drive dmem_ren or dmem_wen, the address and the lanes from the registered request, and hold them stable while dmem_busy is high.
REQ-023 In ACCESS, the block SHALL go to DONE on the first cycle that dmem_busy is low; on that same edge it SHALL capture load_data.
REQ-024 DONE SHALL last one cycle with mem_stall low, then the block SHALL return to IDLE; a new request SHALL be accepted only in IDLE, giving a minimum latency of 2 cycles from acceptance to result.
REQ-025 mem_stall SHALL be high in the acceptance cycle and throughout ACCESS, and low in IDLE and DONE.
REQ-026 Byte enables SHALL be 0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a halfword and 1111 for a word.
REQ-027 Store data SHALL be shifted left by 8*addr[1:0].
REQ-028 Load data SHALL be shifted right by 8*addr[1:0], then sign-extended for LB/LH or zero-extended for LBU/LHU.
REQ-029 If both dren and dwen are high, the store SHALL take priority.
REQ-030 A flush in ACCESS SHALL hold the strobe until dmem_busy is low (the bus transaction is never abandoned), then discard the result and return to IDLE without passing through DONE.
REQ-031 A flush in IDLE SHALL suppress acceptance.

Reset
REQ-032 While RST is high, the block SHALL go to IDLE and drive every output to 0, including load_data, dmem_addr, dmem_wdata and dmem_byte_en.
REQ-033 A reset asserted mid-ACCESS SHALL drop the strobes on the next edge, and the block SHALL ignore any late dmem_busy deassertion.

Configuration
REQ-034 The block SHALL support one optional feature, controlled by the macro PIPE5_DMEM_TIMEOUT_EN.
REQ-035 With PIPE5_DMEM_TIMEOUT_EN defined, the block SHALL have a counter that clears on entry to ACCESS and increments each busy cycle.
REQ-036 When that counter reaches TIMEOUT_CYCLES-1 with dmem_busy still high, the block SHALL pulse bus_fault, drop the strobes and return to IDLE with mem_stall low.
REQ-037 Without PIPE5_DMEM_TIMEOUT_EN, the counter SHALL be absent, bus_fault SHALL be tied to 0, and ACCESS SHALL wait indefinitely.

Verification
REQ-038 LB test: addr 0x1003, dmem_rdata 0x80AABBCC, busy 3 cycles -> byte_en 1000, load_data 0xFFFFFF80, mem_stall high for 4 cycles.
REQ-039 SH test: addr 0x2002, store_wdata 0x0000BEEF -> dmem_wdata 0xBEEF0000, byte_en 1100, dmem_addr 0x2000.
REQ-040 LW test: addr 0x3001 -> mal_addr pulses once, no strobe, mem_stall low the next cycle.
REQ-041 Flush test: assert flush during ACCESS with busy high for 2 cycles -> strobe held until busy is low, no DONE cycle, load_data unchanged.
REQ-042 Timeout test: with PIPE5_DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, busy stuck high -> bus_fault pulses on the 4th ACCESS cycle and the block returns to IDLE.
REQ-043 Reset test: assert RST in the 2nd ACCESS cycle -> all outputs 0 and the block in IDLE on the next edge.
